// File: rtl/sd_sync_fifo.sv
// ---------------------------------------------------------------------------
// sd_sync_fifo
// Single-clock data FIFO for the eMMC controller datapath. It buffers block
// data between the AXI slave and the data engine, both in the aclk domain.
// Each stored word carries one even-parity bit per data byte. Parity is
// generated on write and checked when a word is loaded into the output
// register.
//
// Parameters
//   DATA_W     data width in bits (multiple of 8)
//   ADDR_W     log2 of the depth
//   FWFT       1 = first-word-fall-through, 0 = standard read
//   AF_OFFSET  almost_full  when count >= DEPTH - AF_OFFSET
//   AE_OFFSET  almost_empty when count <= AE_OFFSET
//
// Ports
//   aclk, aresetn        clock (rising edge), async active-low reset
//   flush                synchronous clear of contents and sticky flags
//   wr_en, wr_data       write request and data
//   inj_perr             inverts generated parity bit 0 of the written word
//   full, almost_full    write-side status
//   rd_en                read request (pop when FWFT=1)
//   rd_data, rd_valid    output word and its valid flag
//   empty, almost_empty  read-side status
//   count                words held, including the output register
//   parity_err           sticky: a word failed its parity check
//   wr_err, rd_err       sticky: write while full / read while empty
// ---------------------------------------------------------------------------
module sd_sync_fifo #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int FWFT      = 1,
    parameter int AF_OFFSET = 128,
    parameter int AE_OFFSET = 10
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inj_perr,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              parity_err,
    output logic              wr_err,
    output logic              rd_err
);

    localparam int PAR_W  = DATA_W / 8;
    localparam int WORD_W = DATA_W + PAR_W;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_LEVEL_C = (ADDR_W+1)'(DEPTH - AF_OFFSET);
    localparam logic [ADDR_W:0]   AE_LEVEL_C = (ADDR_W+1)'(AE_OFFSET);
    localparam logic [ADDR_W:0]   CNT_ONE_C  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO_C = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE_C  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO_C = ADDR_W'(0);

    // Even parity per byte; bit i covers data[8*i+7 : 8*i].
    function automatic logic [PAR_W-1:0] gen_parity(input logic [DATA_W-1:0] data);
        logic [PAR_W-1:0] par;
        par = {PAR_W{1'b0}};
        for (int i = 0; i < PAR_W; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              full_r;
    logic              almost_full_r;
    logic              empty_r;
    logic              almost_empty_r;
    logic              parity_err_r;
    logic              wr_err_r;
    logic              rd_err_r;

    logic              wr_acc_s;
    logic              pop_s;
    logic              take_s;
    logic              rd_err_set_s;
    logic              rd_valid_nxt_s;
    logic [ADDR_W:0]   mem_cnt_s;
    logic [ADDR_W:0]   count_nxt_s;
    logic [PAR_W-1:0]  wr_par_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              perr_s;

    // Head-of-memory word and its parity check.
    assign rd_word_s = mem_r[rd_ptr_r];
    assign perr_s    = (gen_parity(rd_word_s[DATA_W-1:0]) != rd_word_s[WORD_W-1:DATA_W]);

    // Write parity, with optional corruption of bit 0 for fault injection.
    always_comb begin
        wr_par_s    = gen_parity(wr_data);
        wr_par_s[0] = wr_par_s[0] ^ inj_perr;
    end

    // Transfer decisions and next count; flush suppresses every transfer.
    always_comb begin
        wr_acc_s       = 1'b0;
        pop_s          = 1'b0;
        take_s         = 1'b0;
        rd_err_set_s   = 1'b0;
        rd_valid_nxt_s = 1'b0;
        mem_cnt_s      = count_r;
        count_nxt_s    = count_r;
        if (flush) begin
            count_nxt_s = CNT_ZERO_C;
        end else begin
            // full_r is the pre-edge state, so a same-cycle pop never frees room.
            wr_acc_s = wr_en & ~full_r;
            if (FWFT != 0) begin
                // Words still in memory exclude the one sitting in the output register.
                pop_s          = rd_en & rd_valid_r;
                mem_cnt_s      = count_r - {{ADDR_W{1'b0}}, rd_valid_r};
                take_s         = (mem_cnt_s != CNT_ZERO_C) & (~rd_valid_r | pop_s);
                rd_err_set_s   = rd_en & ~rd_valid_r;
                rd_valid_nxt_s = take_s | (rd_valid_r & ~pop_s);
            end else begin
                pop_s          = rd_en & ~empty_r;
                take_s         = pop_s;
                rd_err_set_s   = rd_en & empty_r;
                rd_valid_nxt_s = pop_s;
            end
            case ({wr_acc_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE_C;
                2'b01:   count_nxt_s = count_r - CNT_ONE_C;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge aclk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= {wr_par_s, wr_data};
        end
    end

    // Pointers, count, output register and sticky error flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r     <= PTR_ZERO_C;
            rd_ptr_r     <= PTR_ZERO_C;
            count_r      <= CNT_ZERO_C;
            rd_data_r    <= {DATA_W{1'b0}};
            rd_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            wr_err_r     <= 1'b0;
            rd_err_r     <= 1'b0;
        end else if (flush) begin
            wr_ptr_r     <= PTR_ZERO_C;
            rd_ptr_r     <= PTR_ZERO_C;
            count_r      <= CNT_ZERO_C;
            rd_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            wr_err_r     <= 1'b0;
            rd_err_r     <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (take_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE_C;
                rd_data_r <= rd_word_s[DATA_W-1:0];
            end
            rd_valid_r   <= rd_valid_nxt_s;
            count_r      <= count_nxt_s;
            wr_err_r     <= wr_err_r | (wr_en & full_r);
            rd_err_r     <= rd_err_r | rd_err_set_s;
            // Flag rises together with the faulty word appearing on rd_data.
            parity_err_r <= parity_err_r | (take_s & perr_s);
        end
    end

    // Level flags decoded from the next count so they line up with count_r.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full_r         <= 1'b0;
            almost_full_r  <= 1'b0;
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
        end else begin
            full_r         <= (count_nxt_s == DEPTH_C);
            almost_full_r  <= (count_nxt_s >= AF_LEVEL_C);
            empty_r        <= (count_nxt_s == CNT_ZERO_C);
            almost_empty_r <= (count_nxt_s <= AE_LEVEL_C);
        end
    end

    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign empty        = empty_r;
    assign almost_empty = almost_empty_r;
    assign count        = count_r;
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign parity_err   = parity_err_r;
    assign wr_err       = wr_err_r;
    assign rd_err       = rd_err_r;

endmodule

// File: tb/tb_sd_sync_fifo.sv
// Directed bench for sd_sync_fifo: one FWFT=1 instance and one FWFT=0 instance.
module tb_sd_sync_fifo;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    // FWFT=1 instance
    logic        aresetn, flush, wr_en, inj_perr, rd_en;
    logic [31:0] wr_data;
    logic        full, almost_full, rd_valid, empty, almost_empty;
    logic [31:0] rd_data;
    logic [9:0]  count;
    logic        parity_err, wr_err, rd_err;

    // FWFT=0 instance
    logic        aresetn0, flush0, wr_en0, inj_perr0, rd_en0;
    logic [31:0] wr_data0;
    logic        full0, almost_full0, rd_valid0, empty0, almost_empty0;
    logic [31:0] rd_data0;
    logic [9:0]  count0;
    logic        parity_err0, wr_err0, rd_err0;

    int total = 0;
    int bad   = 0;

    sd_sync_fifo #(.DATA_W(32), .ADDR_W(9), .FWFT(1), .AF_OFFSET(128), .AE_OFFSET(10)) dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .inj_perr(inj_perr), .full(full), .almost_full(almost_full), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
        .count(count), .parity_err(parity_err), .wr_err(wr_err), .rd_err(rd_err)
    );

    sd_sync_fifo #(.DATA_W(32), .ADDR_W(9), .FWFT(0), .AF_OFFSET(128), .AE_OFFSET(10)) dut0 (
        .aclk(aclk), .aresetn(aresetn0), .flush(flush0), .wr_en(wr_en0), .wr_data(wr_data0),
        .inj_perr(inj_perr0), .full(full0), .almost_full(almost_full0), .rd_en(rd_en0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .empty(empty0), .almost_empty(almost_empty0),
        .count(count0), .parity_err(parity_err0), .wr_err(wr_err0), .rd_err(rd_err0)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0; flush = 1'b0; wr_en = 1'b0; inj_perr = 1'b0; rd_en = 1'b0; wr_data = 32'd0;
        aresetn0 = 1'b0; flush0 = 1'b0; wr_en0 = 1'b0; inj_perr0 = 1'b0; rd_en0 = 1'b0; wr_data0 = 32'd0;
        #22;
        // reset state
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_ae", 64'(almost_empty), 64'd1);
        check_val("rst_full", 64'(full), 64'd0);
        check_val("rst_af", 64'(almost_full), 64'd0);
        check_val("rst_valid", 64'(rd_valid), 64'd0);
        check_val("rst_data", 64'(rd_data), 64'd0);
        check_val("rst_sticky", 64'({parity_err, wr_err, rd_err}), 64'd0);
        aresetn = 1'b1; aresetn0 = 1'b1;
        tick();

        // first-word latency
        wr_en = 1'b1; wr_data = 32'hA5A5_0001;
        tick();
        wr_en = 1'b0;
        check_val("fw_cnt_n", 64'(count), 64'd1);
        check_val("fw_empty_n", 64'(empty), 64'd0);
        check_val("fw_valid_n", 64'(rd_valid), 64'd0);
        tick();
        check_val("fw_valid_n1", 64'(rd_valid), 64'd1);
        check_val("fw_data_n1", 64'(rd_data), 64'hA5A5_0001);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("fw_pop_cnt", 64'(count), 64'd0);
        check_val("fw_pop_empty", 64'(empty), 64'd1);
        check_val("fw_pop_valid", 64'(rd_valid), 64'd0);

        // fill to full, checking the almost_full threshold every word
        for (int i = 0; i < 512; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            tick();
            check_val("fill_af", 64'(almost_full), 64'((i + 1) >= 384));
            check_val("fill_ae", 64'(almost_empty), 64'((i + 1) <= 10));
        end
        check_val("full_flag", 64'(full), 64'd1);
        check_val("full_cnt", 64'(count), 64'd512);
        check_val("full_werr0", 64'(wr_err), 64'd0);
        wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        check_val("ovf_werr", 64'(wr_err), 64'd1);
        check_val("ovf_cnt", 64'(count), 64'd512);
        rd_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            check_val("drain_valid", 64'(rd_valid), 64'd1);
            check_val("drain_data", 64'(rd_data), 64'(i));
            tick();
        end
        rd_en = 1'b0;
        check_val("drain_empty", 64'(empty), 64'd1);
        check_val("drain_cnt", 64'(count), 64'd0);
        check_val("drain_valid_end", 64'(rd_valid), 64'd0);
        check_val("drain_rerr", 64'(rd_err), 64'd0);
        check_val("werr_sticky", 64'(wr_err), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("flush_werr", 64'(wr_err), 64'd0);

        // move pointers near the top so the steady-state run crosses the wrap
        for (int i = 0; i < 495; i++) begin
            wr_en = 1'b1; wr_data = 32'(i);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 495; i++) begin
            tick();
        end
        rd_en = 1'b0;
        check_val("adv_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 32'(100 + i);
            tick();
        end
        check_val("hold_cnt", 64'(count), 64'd5);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data = 32'(105 + k);
            check_val("wrap_valid", 64'(rd_valid), 64'd1);
            check_val("wrap_data", 64'(rd_data), 64'(100 + k));
            tick();
            check_val("wrap_cnt", 64'(count), 64'd5);
        end
        wr_en = 1'b0;
        for (int k = 20; k < 25; k++) begin
            check_val("wrap_tail", 64'(rd_data), 64'(100 + k));
            tick();
        end
        rd_en = 1'b0;
        check_val("wrap_empty", 64'(empty), 64'd1);
        check_val("wrap_rerr", 64'(rd_err), 64'd0);

        // parity injection on the third word
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 32'h0000_0200 + 32'(i); inj_perr = (i == 2);
            tick();
        end
        wr_en = 1'b0; inj_perr = 1'b0;
        check_val("par_w0", 64'({parity_err, rd_valid, rd_data}), {31'd0, 1'b0, 1'b1, 32'h0000_0200});
        rd_en = 1'b1;
        tick();
        check_val("par_w1", 64'({parity_err, rd_valid, rd_data}), {31'd0, 1'b0, 1'b1, 32'h0000_0201});
        tick();
        check_val("par_w2", 64'({parity_err, rd_valid, rd_data}), {31'd0, 1'b1, 1'b1, 32'h0000_0202});
        tick();
        rd_en = 1'b0;
        check_val("par_sticky", 64'(parity_err), 64'd1);
        check_val("par_empty", 64'(empty), 64'd1);
        tick();
        check_val("par_sticky2", 64'(parity_err), 64'd1);

        // read while empty, then flush with words held
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("rerr_set", 64'(rd_err), 64'd1);
        check_val("rerr_valid", 64'(rd_valid), 64'd0);
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = 32'(i + 50);
            tick();
        end
        wr_en = 1'b0;
        tick();
        check_val("pre_flush_cnt", 64'(count), 64'd7);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_val("flush_cnt", 64'(count), 64'd0);
        check_val("flush_valid", 64'(rd_valid), 64'd0);
        check_val("flush_empty", 64'(empty), 64'd1);
        check_val("flush_sticky", 64'({parity_err, wr_err, rd_err}), 64'd0);

        // standard-read instance
        for (int i = 0; i < 3; i++) begin
            wr_en0 = 1'b1; wr_data0 = 32'h0000_0300 + 32'(i);
            tick();
        end
        wr_en0 = 1'b0;
        check_val("s_cnt3", 64'(count0), 64'd3);
        check_val("s_valid_idle", 64'(rd_valid0), 64'd0);
        rd_en0 = 1'b1;
        tick();
        rd_en0 = 1'b0;
        check_val("s_rd_valid", 64'(rd_valid0), 64'd1);
        check_val("s_rd_data", 64'(rd_data0), 64'h0000_0300);
        check_val("s_rd_cnt", 64'(count0), 64'd2);
        tick();
        check_val("s_valid_drop", 64'(rd_valid0), 64'd0);
        rd_en0 = 1'b1;
        tick();
        check_val("s_rd1", 64'(rd_data0), 64'h0000_0301);
        wr_en0 = 1'b1; wr_data0 = 32'h0000_0400;
        tick();
        check_val("s_rd2", 64'(rd_data0), 64'h0000_0302);
        rd_en0 = 1'b0;
        tick();
        check_val("s_burst_cnt", 64'(count0), 64'd2);
        #2;
        aresetn0 = 1'b0;
        #1;
        check_val("s_arst_cnt", 64'(count0), 64'd0);
        check_val("s_arst_empty", 64'(empty0), 64'd1);
        check_val("s_arst_valid", 64'(rd_valid0), 64'd0);
        wr_en0 = 1'b0;
        tick();
        aresetn0 = 1'b1;
        wr_en0 = 1'b1; wr_data0 = 32'h0000_0500;
        tick();
        wr_en0 = 1'b0;
        check_val("s_post_cnt", 64'(count0), 64'd1);
        rd_en0 = 1'b1;
        tick();
        check_val("s_post_data", 64'(rd_data0), 64'h0000_0500);
        tick();
        rd_en0 = 1'b0;
        check_val("s_rerr", 64'(rd_err0), 64'd1);
        check_val("s_rerr_valid", 64'(rd_valid0), 64'd0);
        check_val("s_perr", 64'(parity_err0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
